// File: rtl/key_event_if.sv
// Key event bus: strobe inputs, valid/ready event output and status.
// The master side is the arbiter and the slave side is the consumer/environment.
interface key_event_if #(
  parameter int KEYS_CNT = 4,
  parameter int KEY_W    = ($clog2(KEYS_CNT) < 1) ? 1 : $clog2(KEYS_CNT)
);
  logic [KEYS_CNT-1:0] key_stb_i;
  logic                evt_valid_o;
  logic                evt_ready_i;
  logic [KEY_W-1:0]    evt_key_o;
  logic [KEYS_CNT-1:0] pending_o;
  logic                overflow_o;
  logic                overflow_clr_i;

  modport master (
    input  key_stb_i, evt_ready_i, overflow_clr_i,
    output evt_valid_o, evt_key_o, pending_o, overflow_o
  );

  modport slave (
    output key_stb_i, evt_ready_i, overflow_clr_i,
    input  evt_valid_o, evt_key_o, pending_o, overflow_o
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Round-robin arbiter that turns per-key press strobes into one valid/ready
// event at a time, with an idle gap after each event and a sticky merge flag.
module key_event_arbiter #(
  parameter int KEYS_CNT   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  key_event_if.master bus
);
  localparam int KEY_W = ($clog2(KEYS_CNT) < 1) ? 1 : $clog2(KEYS_CNT);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(KEYS_CNT - 1);

  typedef enum logic [1:0] {IDLE, VALID, GAP} state_t;

  state_t              state_q, state_d;
  logic [KEYS_CNT-1:0] pending_q, pending_d, clr_mask;
  logic [KEY_W-1:0]    rr_q, rr_d, key_q, key_d, grant_idx, scan_idx;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                valid_q, valid_d, ovf_q, ovf_d;
  logic                grant_found, accept, merge;

  assign accept = valid_q & bus.evt_ready_i;

  // First pending key at or after rr_q, wrapping at KEYS_CNT.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = rr_q;
    scan_idx    = rr_q;
    for (int i = 0; i < KEYS_CNT; i++) begin
      if (!grant_found && pending_q[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = (scan_idx == LAST_KEY) ? '0 : scan_idx + KEY_W'(1);
    end
  end

  // A strobe on the key being accepted re-arms it as a fresh event, not a merge.
  always_comb begin
    clr_mask = '0;
    if (accept) clr_mask[key_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | bus.key_stb_i;
    merge     = |(bus.key_stb_i & pending_q & ~clr_mask);
    ovf_d     = merge | (ovf_q & ~bus.overflow_clr_i);
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    key_d   = key_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          key_d   = grant_idx;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (accept) begin
          valid_d = 1'b0;
          rr_d    = (key_q == LAST_KEY) ? '0 : key_q + KEY_W'(1);
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_q      <= '0;
      gap_q     <= '0;
      valid_q   <= 1'b0;
      key_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      valid_q   <= valid_d;
      key_q     <= key_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.evt_valid_o = valid_q;
  assign bus.evt_key_o   = key_q;
  assign bus.pending_o   = pending_q;
  assign bus.overflow_o  = ovf_q;
endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench: directed strobes push expected (key, cycle) pairs, and
// per-DUT monitors pop and compare on every accepted event.
module tb_key_event_arbiter;
  typedef struct {
    logic [1:0] key;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   t;
  exp_t q[$];
  exp_t q0[$];

  key_event_if #(.KEYS_CNT(4)) bus();
  key_event_if #(.KEYS_CNT(4)) bus0();

  key_event_arbiter #(.KEYS_CNT(4), .GAP_CYCLES(2)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  key_event_arbiter #(.KEYS_CNT(4), .GAP_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goCycle(input int n);
    while (cyc < n) tick();
  endtask

  task automatic sampleAt(input int n);
    goCycle(n);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] stb, input logic clr);
    bus.key_stb_i      = stb;
    bus.overflow_clr_i = clr;
    tick();
    bus.key_stb_i      = '0;
    bus.overflow_clr_i = 1'b0;
  endtask

  task automatic pushExp(input logic [1:0] k, input int c);
    q.push_back('{key: k, cyc: c});
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Every handshake must match the head of the scoreboard in key and cycle.
  always @(negedge clk) begin
    if (!rst && bus.evt_valid_o && bus.evt_ready_i) begin
      checkCount++;
      if (q.size() == 0) begin
        $display("[TB] FAIL unexpected_event: got key %0d at cycle %0d, expected none", bus.evt_key_o, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.evt_key_o === e.key && (e.cyc < 0 || e.cyc == cyc)) passCount++;
        else $display("[TB] FAIL event: got key %0d at cycle %0d, expected key %0d at cycle %0d",
                      bus.evt_key_o, cyc, e.key, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus0.evt_valid_o && bus0.evt_ready_i) begin
      checkCount++;
      if (q0.size() == 0) begin
        $display("[TB] FAIL unexpected_event_gap0: got key %0d at cycle %0d, expected none", bus0.evt_key_o, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (bus0.evt_key_o === e.key && e.cyc == cyc) passCount++;
        else $display("[TB] FAIL event_gap0: got key %0d at cycle %0d, expected key %0d at cycle %0d",
                      bus0.evt_key_o, cyc, e.key, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.key_stb_i       = '0;
    bus.evt_ready_i     = 1'b1;
    bus.overflow_clr_i  = 1'b0;
    bus0.key_stb_i      = '0;
    bus0.evt_ready_i    = 1'b1;
    bus0.overflow_clr_i = 1'b0;

    doReset();
    @(negedge clk);
    checkOutput("reset_valid",    32'(bus.evt_valid_o), 0);
    checkOutput("reset_key",      32'(bus.evt_key_o),   0);
    checkOutput("reset_pending",  32'(bus.pending_o),   0);
    checkOutput("reset_overflow", 32'(bus.overflow_o),  0);

    $display("[TB] single strobe on key 2");
    t = cyc + 1;
    goCycle(t);
    pushExp(2, t + 2);
    applyStimulus(4'b0100, 1'b0);
    sampleAt(t + 1);
    checkOutput("single_pending", 32'(bus.pending_o), 32'h4);
    checkOutput("single_no_early_valid", 32'(bus.evt_valid_o), 0);
    sampleAt(t + 3);
    checkOutput("gap_valid_c3",   32'(bus.evt_valid_o), 0);
    checkOutput("single_cleared", 32'(bus.pending_o),   0);
    sampleAt(t + 4);
    checkOutput("gap_valid_c4",   32'(bus.evt_valid_o), 0);
    checkOutput("key_hold",       32'(bus.evt_key_o),   2);
    sampleAt(t + 5);
    checkOutput("gap_valid_c5",   32'(bus.evt_valid_o), 0);
    goCycle(t + 8);
    doReset();

    $display("[TB] all keys at once");
    t = cyc + 1;
    goCycle(t);
    pushExp(0, t + 2);
    pushExp(1, t + 6);
    pushExp(2, t + 10);
    pushExp(3, t + 14);
    applyStimulus(4'b1111, 1'b0);
    sampleAt(t + 1);
    checkOutput("all_pending", 32'(bus.pending_o), 32'hf);
    sampleAt(t + 16);
    checkOutput("all_no_overflow", 32'(bus.overflow_o), 0);
    checkOutput("all_drained",     32'(bus.pending_o),  0);

    $display("[TB] round-robin order");
    t = t + 18;
    goCycle(t);
    pushExp(0, t + 2);
    pushExp(3, t + 6);
    applyStimulus(4'b1001, 1'b0);
    t = t + 10;
    goCycle(t);
    pushExp(0, t + 2);
    applyStimulus(4'b0001, 1'b0);
    t = t + 6;
    goCycle(t);
    pushExp(1, t + 2);
    pushExp(3, t + 6);
    applyStimulus(4'b1010, 1'b0);

    $display("[TB] merge and overflow");
    t = t + 10;
    goCycle(t);
    bus.evt_ready_i = 1'b0;
    applyStimulus(4'b0010, 1'b0);
    goCycle(t + 3);
    applyStimulus(4'b0010, 1'b0);
    sampleAt(t + 4);
    checkOutput("ovf_set",      32'(bus.overflow_o),  1);
    checkOutput("ovf_valid",    32'(bus.evt_valid_o), 1);
    checkOutput("ovf_key",      32'(bus.evt_key_o),   1);
    goCycle(t + 5);
    applyStimulus(4'b0010, 1'b1);
    sampleAt(t + 6);
    checkOutput("ovf_set_beats_clr", 32'(bus.overflow_o), 1);
    goCycle(t + 7);
    applyStimulus(4'b0000, 1'b1);
    sampleAt(t + 8);
    checkOutput("ovf_cleared", 32'(bus.overflow_o), 0);
    goCycle(t + 9);
    pushExp(1, t + 9);
    bus.evt_ready_i = 1'b1;
    sampleAt(t + 10);
    checkOutput("merge_single_event", 32'(bus.pending_o), 0);

    $display("[TB] re-strobe during acceptance");
    t = t + 14;
    goCycle(t);
    pushExp(2, t + 2);
    pushExp(2, t + 6);
    applyStimulus(4'b0100, 1'b0);
    goCycle(t + 2);
    applyStimulus(4'b0100, 1'b0);
    sampleAt(t + 3);
    checkOutput("restrobe_pending",  32'(bus.pending_o),  32'h4);
    checkOutput("restrobe_overflow", 32'(bus.overflow_o), 0);
    sampleAt(t + 7);
    checkOutput("restrobe_drained",  32'(bus.pending_o),  0);

    $display("[TB] reset mid-event");
    t = t + 10;
    goCycle(t);
    bus.evt_ready_i = 1'b0;
    applyStimulus(4'b1010, 1'b0);
    sampleAt(t + 3);
    checkOutput("pre_rst_valid",   32'(bus.evt_valid_o), 1);
    checkOutput("pre_rst_key",     32'(bus.evt_key_o),   3);
    checkOutput("pre_rst_pending", 32'(bus.pending_o),   32'ha);
    goCycle(t + 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sampleAt(t + 5);
    checkOutput("rst_valid",   32'(bus.evt_valid_o), 0);
    checkOutput("rst_key",     32'(bus.evt_key_o),   0);
    checkOutput("rst_pending", 32'(bus.pending_o),   0);
    goCycle(t + 6);
    bus.evt_ready_i = 1'b1;
    sampleAt(t + 9);
    checkOutput("rst_stays_idle", 32'(bus.evt_valid_o), 0);

    $display("[TB] back-to-back with zero gap");
    t = cyc + 1;
    goCycle(t);
    q0.push_back('{key: 2'd0, cyc: t + 2});
    q0.push_back('{key: 2'd1, cyc: t + 4});
    q0.push_back('{key: 2'd2, cyc: t + 6});
    q0.push_back('{key: 2'd3, cyc: t + 8});
    bus0.key_stb_i = 4'b1111;
    tick();
    bus0.key_stb_i = '0;
    sampleAt(t + 11);
    checkOutput("scoreboard_drained",      32'(q.size()),  0);
    checkOutput("scoreboard_gap0_drained", 32'(q0.size()), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
